mu0_control_unit: RTL and testbench

//  Parametrised MU0 control unit: phase sequencer plus opcode decoder in one block. Generates

---
 rtl/mu0_control_unit_if.sv | 42 ++++
 rtl/mu0_control_unit.sv | 181 ++++++++++++++++++
 tb/tb_mu0_control_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mu0_control_unit_if.sv
// MU0 control-unit bus: IR opcode, ACC value and memory handshake in, phase and datapath strobes out.
// master = datapath/memory side, slave = control unit.
interface mu0_control_unit_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
);
    logic [OP_W-1:0]   OP;
    logic [DATA_W-1:0] ACC_OUT;
    logic              MEM_READY;
    logic              RESUME;

    logic              FETCH;
    logic              EXEC1;
    logic              EXEC2;
    logic              HALTED;
    logic              ILLEGAL;
    logic              IR_LOAD;
    logic              EXTRA;
    logic              MUX1;
    logic              MUX3;
    logic              SLOAD;
    logic              CNT_EN;
    logic              WREN;
    logic              SLOAD_ACC;
    logic              shift;
    logic              enable_acc;
    logic              add_sub;
    logic              mux4;
    logic [31:0]       RETIRED;

    modport master (
        output OP, ACC_OUT, MEM_READY, RESUME,
        input  FETCH, EXEC1, EXEC2, HALTED, ILLEGAL, IR_LOAD, EXTRA, MUX1, MUX3,
               SLOAD, CNT_EN, WREN, SLOAD_ACC, shift, enable_acc, add_sub, mux4, RETIRED
    );

    modport slave (
        input  OP, ACC_OUT, MEM_READY, RESUME,
        output FETCH, EXEC1, EXEC2, HALTED, ILLEGAL, IR_LOAD, EXTRA, MUX1, MUX3,
               SLOAD, CNT_EN, WREN, SLOAD_ACC, shift, enable_acc, add_sub, mux4, RETIRED
    );
endinterface

// File: rtl/mu0_control_unit.sv
// MU0 control unit: FETCH/EXEC1/EXEC2/HALT sequencer and opcode decoder with memory wait states.
// Optional retired-instruction counter enabled by defining MU0_RETIRE_CNT_EN.
//   state | meaning
//   FETCH | read instruction into IR, wait for MEM_READY
//   EXEC1 | first execute phase; single-phase opcodes complete here
//   EXEC2 | memory-operand phase of LDA/ADD/SUB
//   HALT  | stopped after STP until RESUME
module mu0_control_unit #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input logic               CLK,
    input logic               RST_N,
    mu0_control_unit_if.slave bus
);

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_STA = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_JMI = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_JEQ = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_STP = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_LDI = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_LSL = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_LSR = OP_W'(4'hA);
    localparam logic [OP_W-1:0] OP_ASR = OP_W'(4'hB);

    typedef enum logic [3:0] {
        ST_FETCH = 4'b0001,
        ST_EXEC1 = 4'b0010,
        ST_EXEC2 = 4'b0100,
        ST_HALT  = 4'b1000
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic acc_eq, acc_mi, ready;
    logic ir_load, extra, mux1, mux3, sload, cnt_en, wren, sload_acc, shift_s, enable_acc, mux4;

    assign acc_eq = (bus.ACC_OUT == '0);
    assign acc_mi = bus.ACC_OUT[DATA_W-1];
    assign ready  = bus.MEM_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        ir_load    = 1'b0;
        extra      = 1'b0;
        mux1       = 1'b0;
        mux3       = 1'b0;
        sload      = 1'b0;
        cnt_en     = 1'b0;
        wren       = 1'b0;
        sload_acc  = 1'b0;
        shift_s    = 1'b0;
        enable_acc = 1'b0;
        mux4       = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                ir_load = ready;
                if (ready) state_d = ST_EXEC1;
            end
            ST_EXEC1: begin
                case (bus.OP)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        extra   = 1'b1;
                        mux1    = 1'b1;
                        mux3    = 1'b1;
                        state_d = ST_EXEC2;
                    end
                    OP_STA: begin
                        mux1   = 1'b1;
                        wren   = ready;
                        cnt_en = ready;
                        if (ready) state_d = ST_FETCH;
                    end
                    OP_JMP, OP_JMI, OP_JEQ: begin
                        // Unconditional jump, or a conditional one whose flag is set, loads PC
                        if ((bus.OP == OP_JMP) || ((bus.OP == OP_JMI) && acc_mi) ||
                            ((bus.OP == OP_JEQ) && acc_eq)) begin
                            mux1  = 1'b1;
                            sload = 1'b1;
                        end else begin
                            cnt_en = 1'b1;
                        end
                        state_d = ST_FETCH;
                    end
                    OP_STP: state_d = ST_HALT;
                    OP_LDI: begin
                        mux3       = 1'b1;
                        sload_acc  = 1'b1;
                        enable_acc = 1'b1;
                        cnt_en     = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OP_LSL, OP_LSR, OP_ASR: begin
                        enable_acc = 1'b1;
                        cnt_en     = 1'b1;
                        mux4       = (bus.OP == OP_LSR);
                        shift_s    = (bus.OP == OP_ASR);
                        state_d    = ST_FETCH;
                    end
                    default: begin
                        cnt_en    = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC2: begin
                mux1       = 1'b1;
                mux3       = (bus.OP == OP_LDA);
                sload_acc  = ready;
                enable_acc = ready;
                cnt_en     = ready;
                if (ready) state_d = ST_FETCH;
            end
            ST_HALT: begin
                if (bus.RESUME) begin
                    cnt_en  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Strobes are gated by RST_N so nothing fires while reset holds the state in FETCH
    assign bus.IR_LOAD    = ir_load & RST_N;
    assign bus.CNT_EN     = cnt_en & RST_N;
    assign bus.SLOAD      = sload & RST_N;
    assign bus.WREN       = wren & RST_N;
    assign bus.SLOAD_ACC  = sload_acc & RST_N;
    assign bus.enable_acc = enable_acc & RST_N;
    assign bus.shift      = shift_s & RST_N;
    assign bus.EXTRA      = extra;
    assign bus.MUX1       = mux1;
    assign bus.MUX3       = mux3;
    assign bus.mux4       = mux4;
    assign bus.add_sub    = (bus.OP == OP_ADD);

    assign bus.FETCH   = (state_q == ST_FETCH);
    assign bus.EXEC1   = (state_q == ST_EXEC1);
    assign bus.EXEC2   = (state_q == ST_EXEC2);
    assign bus.HALTED  = (state_q == ST_HALT);
    assign bus.ILLEGAL = illegal_q;

`ifdef MU0_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic        retire;

    always_comb begin
        retire    = ((state_q == ST_EXEC1) || (state_q == ST_EXEC2)) &&
                    ((state_d == ST_FETCH) || (state_d == ST_HALT));
        retired_d = retired_q + 32'(retire);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) retired_q <= 32'd0;
        else        retired_q <= retired_d;
    end

    assign bus.RETIRED = retired_q;
`else
    assign bus.RETIRED = 32'd0;
`endif

endmodule

// File: tb/tb_mu0_control_unit.sv
// Directed bench for mu0_control_unit: driver pushes per-cycle expectations, negedge monitor checks.
module tb_mu0_control_unit;

    localparam int DATA_W = 16;
    localparam int OP_W   = 4;

    localparam logic [11:0] IRL = 12'h800, EXT = 12'h400, M1 = 12'h200, M3 = 12'h100;
    localparam logic [11:0] SL  = 12'h080, CE  = 12'h040, WR = 12'h020, SLA = 12'h010;
    localparam logic [11:0] SH  = 12'h008, EA  = 12'h004, AS = 12'h002, M4  = 12'h001;
    localparam logic [11:0] ALL = 12'hFFF;
    localparam logic [3:0]  PF = 4'b1000, PE1 = 4'b0100, PE2 = 4'b0010, PH = 4'b0001;

`ifdef MU0_RETIRE_CNT_EN
    localparam bit RET_ON = 1'b1;
`else
    localparam bit RET_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N;

    mu0_control_unit_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    mu0_control_unit #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic [3:0]  ph;
        logic [11:0] st;
        logic [11:0] mk;
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic        ill_m = 1'b0;
    logic [31:0] ret_m = 32'd0;

    task automatic chk(input string nm, input logic [3:0] ph, input logic [11:0] st,
                       input logic [11:0] mk = ALL);
        exp_t e;
        e.nm = nm; e.ph = ph; e.st = st; e.mk = mk; e.ill = ill_m; e.ret = ret_m;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic retire();
        if (RET_ON) ret_m = ret_m + 32'd1;
    endtask

    // Monitor: compares whatever expectation the driver queued for the current cycle
    initial begin
        exp_t        e;
        logic [3:0]  aph;
        logic [11:0] ast;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                aph = {bus.FETCH, bus.EXEC1, bus.EXEC2, bus.HALTED};
                ast = {bus.IR_LOAD, bus.EXTRA, bus.MUX1, bus.MUX3, bus.SLOAD, bus.CNT_EN,
                       bus.WREN, bus.SLOAD_ACC, bus.shift, bus.enable_acc, bus.add_sub, bus.mux4};
                n_chk++;
                if (aph !== e.ph) begin
                    n_fail++;
                    $display("FAIL %s phase: got %b want %b", e.nm, aph, e.ph);
                end
                n_chk++;
                if ((ast & e.mk) !== (e.st & e.mk)) begin
                    n_fail++;
                    $display("FAIL %s strobes: got %b want %b (mask %b)", e.nm, ast & e.mk,
                             e.st & e.mk, e.mk);
                end
                n_chk++;
                if (bus.ILLEGAL !== e.ill) begin
                    n_fail++;
                    $display("FAIL %s ILLEGAL: got %b want %b", e.nm, bus.ILLEGAL, e.ill);
                end
                n_chk++;
                if (bus.RETIRED !== e.ret) begin
                    n_fail++;
                    $display("FAIL %s RETIRED: got %0d want %0d", e.nm, bus.RETIRED, e.ret);
                end
            end
        end
    end

    initial begin
        RST_N          = 1'b0;
        bus.OP         = 4'h0;
        bus.ACC_OUT    = 16'h1234;
        bus.MEM_READY  = 1'b1;
        bus.RESUME     = 1'b0;
        @(posedge CLK);
        #1;
        chk("reset", PF, 12'h000);
        RST_N = 1'b1;

        // LDA, ADD, JMP, STP: the retire sequence
        chk("lda_f", PF, IRL);
        chk("lda_e1", PE1, EXT | M1 | M3);
        chk("lda_e2", PE2, M1 | M3 | SLA | EA | CE);
        retire();
        bus.OP = 4'h2;
        chk("add_f", PF, IRL | AS);
        chk("add_e1", PE1, EXT | M1 | AS, ALL & ~M3);
        chk("add_e2", PE2, M1 | SLA | EA | CE | AS);
        retire();
        bus.OP = 4'h4;
        chk("jmp_f", PF, IRL);
        chk("jmp_e1", PE1, M1 | SL);
        retire();
        bus.OP = 4'h7;
        chk("stp_f", PF, IRL);
        chk("stp_e1", PE1, 12'h000);
        retire();
        for (int i = 0; i < 10; i++) begin
            bus.MEM_READY = i[0];
            chk("halt", PH, 12'h000);
        end
        bus.MEM_READY = 1'b1;
        bus.RESUME    = 1'b1;
        chk("resume", PH, CE);
        bus.RESUME = 1'b0;

        // conditional jumps
        bus.OP = 4'h6; bus.ACC_OUT = 16'h0000;
        chk("jeq_t_f", PF, IRL);
        chk("jeq_t_e1", PE1, M1 | SL);
        retire();
        bus.ACC_OUT = 16'h0001;
        chk("jeq_n_f", PF, IRL);
        chk("jeq_n_e1", PE1, CE);
        retire();
        bus.OP = 4'h5; bus.ACC_OUT = 16'h8000;
        chk("jmi_t_f", PF, IRL);
        chk("jmi_t_e1", PE1, M1 | SL);
        retire();
        bus.ACC_OUT = 16'h7FFF;
        chk("jmi_n_f", PF, IRL);
        chk("jmi_n_e1", PE1, CE);
        retire();

        // STA with fetch wait then three EXEC1 wait states
        bus.OP = 4'h1; bus.MEM_READY = 1'b0;
        chk("sta_fwait", PF, 12'h000);
        bus.MEM_READY = 1'b1;
        chk("sta_f", PF, IRL);
        bus.MEM_READY = 1'b0;
        for (int i = 0; i < 3; i++) chk("sta_wait", PE1, M1);
        bus.MEM_READY = 1'b1;
        chk("sta_e1", PE1, M1 | WR | CE);
        retire();

        // LDA with EXEC2 wait state
        bus.OP = 4'h0;
        chk("ldaw_f", PF, IRL);
        chk("ldaw_e1", PE1, EXT | M1 | M3);
        bus.MEM_READY = 1'b0;
        chk("ldaw_wait", PE2, M1 | M3);
        bus.MEM_READY = 1'b1;
        chk("ldaw_e2", PE2, M1 | M3 | SLA | EA | CE);
        retire();

        // LDI and shifts
        bus.OP = 4'h8;
        chk("ldi_f", PF, IRL);
        chk("ldi_e1", PE1, M3 | SLA | EA | CE);
        retire();
        bus.OP = 4'h9;
        chk("lsl_f", PF, IRL);
        chk("lsl_e1", PE1, EA | CE);
        retire();
        bus.OP = 4'hA;
        chk("lsr_f", PF, IRL);
        chk("lsr_e1", PE1, EA | CE | M4);
        retire();
        bus.OP = 4'hB;
        chk("asr_f", PF, IRL);
        chk("asr_e1", PE1, EA | CE | SH);
        retire();

        // illegal opcode, sticky flag, reset mid-EXEC2
        bus.OP = 4'hD;
        chk("ill_f", PF, IRL);
        chk("ill_e1", PE1, CE);
        retire();
        ill_m = 1'b1;
        bus.OP = 4'h0;
        chk("ill_sticky_f", PF, IRL);
        chk("ill_sticky_e1", PE1, EXT | M1 | M3);
        RST_N = 1'b0;
        ill_m = 1'b0;
        ret_m = 32'd0;
        chk("rst_mid_e2", PF, 12'h000);
        RST_N = 1'b1;
        chk("post_rst_f", PF, IRL);
        chk("post_rst_e1", PE1, EXT | M1 | M3);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge CLK);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
